layer_result_packer: RTL

//   Write-side counterpart of the second-layer input memory. It accepts a stream of 8-bit
//   CNN layer results and packs them MSB-first into 32-bit words: the first byte goes to
//   [31:24]. A final partial word is zero-padded in its low bytes. Packed words are stored
//   in an internal word memory. The next stage or the testbench reads them back through a

---
 rtl/cnn_pkg.sv | 32 +++
 rtl/layer_result_packer_if.sv | 27 ++
 rtl/layer_result_packer_byte_word_packer.sv | 34 +++
 rtl/layer_result_packer.sv | 111 +++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, packer state encoding and the partial-word zero-pad helper.
// Pure declarations; no timing.
// Imported by the packer top level and its byte-to-word sub-module.
package cnn_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 43;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } pk_state_t;

  // lane = number of bytes already held in shreg; they are moved to the top of the word.
  function automatic logic [WORD_W-1:0] pad_word(input logic [23:0] shreg,
                                                 input logic [1:0]  lane);
    logic [WORD_W-1:0] w;
    case (lane)
      2'd1:    w = {shreg[7:0], 24'h0};
      2'd2:    w = {shreg[15:0], 16'h0};
      2'd3:    w = {shreg[23:0], 8'h0};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/layer_result_packer_if.sv
// Byte stream, job control, status and read-port signals of the result packer.
// No logic; master drives job/stream/read address, slave returns status and data.
// in_ready is the only stream backpressure; the read port never stalls.
interface layer_result_packer_if;
  logic                          start;
  logic [cnn_pkg::CNT_W-1:0]     num_bytes;
  logic                          in_valid;
  logic [cnn_pkg::BYTE_W-1:0]    in_data;
  logic                          in_last;
  logic                          in_ready;
  logic [cnn_pkg::ADDR_W-1:0]    rd_addr;
  logic [cnn_pkg::WORD_W-1:0]    rd_data;
  logic [cnn_pkg::ADDR_W:0]      words_written;
  logic                          busy;
  logic                          done;
  logic                          overflow;

  modport master (
    output start, num_bytes, in_valid, in_data, in_last, rd_addr,
    input  in_ready, rd_data, words_written, busy, done, overflow
  );

  modport slave (
    input  start, num_bytes, in_valid, in_data, in_last, rd_addr,
    output in_ready, rd_data, words_written, busy, done, overflow
  );
endinterface

// File: rtl/layer_result_packer_byte_word_packer.sv
// Collects bytes MSB-first into 32-bit words; flush emits a zero-padded partial word.
// word_valid/word are combinational: the fourth byte's word is ready on its accept cycle.
// No backpressure of its own; the caller only asserts accept when it can take a word.
module byte_word_packer
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic              flush,
  input  logic [BYTE_W-1:0] data,
  output logic [1:0]        lane,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [23:0] shreg;

  // Shift accepted bytes in; a completed word or a flush empties the register.
  always_ff @(posedge clk) begin
    if (rst || clear || flush) begin
      lane  <= 2'd0;
      shreg <= 24'h0;
    end else if (accept) begin
      lane  <= lane + 2'd1;
      shreg <= (lane == 2'd3) ? 24'h0 : {shreg[15:0], data};
    end
  end

  assign word_valid = flush || (accept && (lane == 2'd3));
  assign word       = flush ? pad_word(shreg, lane) : {shreg, data};

endmodule

// File: rtl/layer_result_packer.sv
// Packs a job of 8-bit layer results into 32-bit words stored in a 43-word memory.
// Full word stored on the edge that accepts its 4th byte; rd_data is one cycle behind rd_addr.
// in_ready only in PACK; words past the end of memory are dropped and flagged sticky.
module layer_result_packer
  import cnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  layer_result_packer_if.slave  bus
);

  pk_state_t         state, state_nxt;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  byte_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              overflow;
  logic [WORD_W-1:0] rd_data;
  logic [WORD_W-1:0] mem [0:DEPTH-1];

  logic              start_ok;
  logic              accept;
  logic              job_end;
  logic              in_ready;
  logic [1:0]        lane;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic              mem_full;

  assign start_ok = bus.start && ((state == IDLE) || (state == DONE));
  assign accept   = bus.in_valid && in_ready;
  // in_last and a count match on the same byte are one end condition.
  assign job_end  = accept && (bus.in_last ||
                    (({1'b0, byte_cnt} + (CNT_W+1)'(1)) == {1'b0, num_q}));
  assign mem_full = (wr_ptr == ADDR_W'(DEPTH));

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .accept     (accept),
    .flush      (state == FLUSH),
    .data       (bus.in_data),
    .lane       (lane),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode; a job ending mid-word takes one FLUSH cycle.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) state_nxt = (bus.num_bytes != '0) ? PACK : DONE;
      end
      PACK: begin
        in_ready = 1'b1;
        if (job_end) state_nxt = (lane == 2'd3) ? DONE : FLUSH;
      end
      FLUSH:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job bookkeeping: byte count, write pointer (doubles as words_written), overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q    <= '0;
      byte_cnt <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (start_ok) begin
      num_q    <= bus.num_bytes;
      byte_cnt <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) byte_cnt <= byte_cnt + CNT_W'(1);
      if (word_valid) begin
        if (mem_full) overflow <= 1'b1;
        else          wr_ptr   <= wr_ptr + ADDR_W'(1);
      end
    end
  end

  // Word memory; contents survive reset, a word landing on a reset edge is discarded.
  always_ff @(posedge clk) begin
    if (!rst && word_valid && !mem_full) mem[wr_ptr] <= word;
  end

  // Registered read port; same-address write in this cycle is not visible until next read.
  always_ff @(posedge clk) begin
    if (rst)                           rd_data <= '0;
    else if (bus.rd_addr < ADDR_W'(DEPTH)) rd_data <= mem[bus.rd_addr];
    else                               rd_data <= '0;
  end

  assign bus.in_ready      = in_ready;
  assign bus.rd_data       = rd_data;
  assign bus.words_written = {1'b0, wr_ptr};
  assign bus.busy          = (state == PACK) || (state == FLUSH);
  assign bus.done          = (state == DONE);
  assign bus.overflow      = overflow;

endmodule
